// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// ALU/mux select codes (the ALU select codes are also consumed by alu_control).
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True in the last cycle of an instruction; TRAP never retires.
  function automatic logic retires(state_t s, logic mem_ready);
    case (s)
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: retires = 1'b1;
      S_MEM_WR:                                       retires = mem_ready;
      default:                                        retires = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Purpose: combinational map from FSM state (and mem_ready) to datapath strobes.
// Latency: zero cycles, purely combinational.
// Backpressure: mem_ready gates only the FETCH writes; all other strobes hold while stalled.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      // Branch target is precomputed here so BRANCH only needs the compare.
      S_DECODE:    alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Purpose: multicycle MIPS sequencing FSM with retire counter and sticky illegal-opcode flag.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles; retire is registered one cycle after the last state.
// Backpressure: mem_ready low in FETCH/MEM_RD/MEM_WR holds the state with strobes stable.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic [3:0]       state_dbg
);

  state_t state, next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = S_R_EXEC;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_ADDI:      next_state = S_ADDI_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_TRAP;
        endcase
      end
      // IR still holds the opcode, so lw/sw split is made after address calc.
      S_MEM_ADDR:  next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WR:    if (mem_ready) next_state = S_FETCH;
      S_R_EXEC:    next_state = S_R_WB;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_TRAP:      next_state = S_TRAP;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire      <= 1'b0;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      retire <= retires(state, mem_ready);
      if (retires(state, mem_ready)) instr_count <= instr_count + CNT_W'(1);
      illegal <= illegal | (next_state == S_TRAP);
    end
  end

  mc_output_decode u_decode (
    .state         (state),
    .mem_ready     (mem_ready),
    .pc_write      (PCWrite),
    .pc_write_cond (PCWriteCond),
    .iord          (IorD),
    .mem_read      (MemRead),
    .mem_write     (MemWrite),
    .ir_write      (IRWrite),
    .mem_to_reg    (MemtoReg),
    .reg_dst       (RegDst),
    .reg_write     (RegWrite),
    .alu_src_a     (ALUSrcA),
    .alu_src_b     (ALUSrcB),
    .alu_op        (ALUOp),
    .pc_source     (PCSource)
  );

  assign pc_en     = PCWrite | (PCWriteCond & zero_flag);
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench: an instruction-level model queues the expected outputs for
// every cycle; a monitor on the falling edge pops and compares.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [5:0] opcode = '0;
  logic zero_flag = 1'b0;
  logic mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic retire, illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0] state_dbg;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .retire(retire), .instr_count(instr_count),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, pc_en, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
  } strb_t;

  typedef struct packed {
    state_t st;
    strb_t s;
    logic ret;
    logic ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  strb_t act_s;
  assign act_s = {PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  bit ret_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobes straight from the per-phase table of the controller's contract.
  function automatic strb_t exp_strobes(state_t ph, logic mr, logic zf);
    strb_t s = '0;
    case (ph)
      S_FETCH:     begin s.mrd = 1; s.srcb = 2'b01; s.irw = mr; s.pcw = mr; s.pc_en = mr; end
      S_DECODE:    s.srcb = 2'b11;
      S_MEM_ADDR:  begin s.srca = 1; s.srcb = 2'b10; end
      S_MEM_RD:    begin s.mrd = 1; s.iord = 1; end
      S_MEM_WR:    begin s.mwr = 1; s.iord = 1; end
      S_MEM_WB:    begin s.rw = 1; s.m2r = 1; end
      S_R_EXEC:    begin s.srca = 1; s.aluop = 2'b10; end
      S_R_WB:      begin s.rw = 1; s.rdst = 1; end
      S_ADDI_EXEC: begin s.srca = 1; s.srcb = 2'b10; end
      S_ADDI_WB:   s.rw = 1;
      S_BRANCH:    begin s.srca = 1; s.aluop = 2'b01; s.pcwc = 1; s.pcsrc = 2'b01; s.pc_en = zf; end
      S_JUMP:      begin s.pcw = 1; s.pcsrc = 2'b10; s.pc_en = 1; end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus: drive inputs after the edge, queue what the DUT must show.
  task automatic cycle(input state_t ph, input logic mr, input logic zf,
                       input logic [5:0] op, input bit retiring);
    exp_t e;
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero_flag = zf;
    opcode    = op;
    e.ret = ret_pend;
    if (ret_pend) exp_cnt++;
    ret_pend = retiring;
    e.st  = ph;
    e.s   = exp_strobes(ph, mr, zf);
    e.ill = (ph == S_TRAP);
    e.cnt = exp_cnt[CNT_W-1:0];
    q.push_back(e);
  endtask

  task automatic mem_phase(input state_t ph, input logic [5:0] op, input int nst, input bit ret_on_done);
    for (int i = 0; i < nst; i++) cycle(ph, 1'b0, rb(), op, 1'b0);
    cycle(ph, 1'b1, rb(), op, ret_on_done);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fst, input int mst, input logic zf_br);
    mem_phase(S_FETCH, 6'($urandom), fst, 1'b0);
    cycle(S_DECODE, rb(), rb(), op, 1'b0);
    case (op)
      6'b000000: begin cycle(S_R_EXEC, rb(), rb(), op, 0); cycle(S_R_WB, rb(), rb(), op, 1); end
      6'b001000: begin cycle(S_ADDI_EXEC, rb(), rb(), op, 0); cycle(S_ADDI_WB, rb(), rb(), op, 1); end
      6'b100011: begin
        cycle(S_MEM_ADDR, rb(), rb(), op, 0);
        mem_phase(S_MEM_RD, op, mst, 1'b0);
        cycle(S_MEM_WB, rb(), rb(), op, 1);
      end
      6'b101011: begin
        cycle(S_MEM_ADDR, rb(), rb(), op, 0);
        mem_phase(S_MEM_WR, op, mst, 1'b1);
      end
      6'b000100: cycle(S_BRANCH, rb(), zf_br, op, 1);
      default:   cycle(S_JUMP, rb(), rb(), op, 1);
    endcase
  endtask

  // Async reset away from the clock edge; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_strobes", 32'(act_s), 32'h0);
    check("rst_retire", 32'(retire), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    exp_cnt  = 0;
    ret_pend = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state", 32'(state_dbg), 32'(e.st));
        check("strobes", 32'(act_s), 32'(e.s));
        check("retire", 32'(retire), 32'(e.ret));
        check("illegal", 32'(illegal), 32'(e.ill));
        check("instr_count", 32'(instr_count), 32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #(10 * 20000);
    $display("FAIL watchdog: simulation did not complete within cycle budget");
    $fatal(1);
  end

  initial begin : stim
    logic [5:0] ops [6];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b001000; ops[4] = 6'b000100; ops[5] = 6'b000010;

    do_reset();
    run_instr(6'b000000, 0, 0, 1'b0);   // R-type, no stalls
    run_instr(6'b100011, 0, 2, 1'b0);   // lw, 2-cycle MEM_RD stall
    run_instr(6'b000100, 0, 0, 1'b1);   // beq taken
    run_instr(6'b000100, 0, 0, 1'b0);   // beq not taken
    run_instr(6'b101011, 1, 1, 1'b0);   // sw with fetch and write stalls

    for (int n = 0; n < 300; n++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                $urandom_range(0, 2), rb());

    // Counter wrap on the 4-bit counter, then abort an sw mid-stall.
    do_reset();
    for (int n = 0; n < 17; n++) run_instr(6'b000010, 0, 0, 1'b0);
    mem_phase(S_FETCH, 6'b000010, 0, 1'b0);
    cycle(S_DECODE, 1'b1, 1'b0, 6'b101011, 1'b0);
    cycle(S_MEM_ADDR, 1'b1, 1'b0, 6'b101011, 1'b0);
    cycle(S_MEM_WR, 1'b0, 1'b0, 6'b101011, 1'b0);
    do_reset();

    // Unsupported opcode parks the FSM in TRAP.
    mem_phase(S_FETCH, 6'b111111, 0, 1'b0);
    cycle(S_DECODE, rb(), rb(), 6'b111111, 1'b0);
    for (int n = 0; n < 20; n++) cycle(S_TRAP, rb(), rb(), 6'b111111, 1'b0);
    do_reset();

    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
